mux_select_arbiter: RTL and testbench

- Upstream control stage for the 2:1 gate-level mux. It arbitrates between two requesters (A, B) and drives the mux `select` line.
- Registered outputs give a glitch-free, held select. Grants use a request/grant/done handshake with round-robin fairness and a bounded hold time.
- Mux convention: `select`=1 routes input a; `select`=0 routes input b.

---
 rtl/mux_ctrl_pkg.sv | 14 +
 rtl/hold_counter.sv | 26 ++
 rtl/mux_select_arbiter.sv | 103 ++++++++++
 tb/tb_mux_select_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared types and constants for the 2:1 mux select arbiter.
// Select encoding and arbiter state live here.
package mux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/hold_counter.sv
// Grant hold-time counter: clear loads 1 on grant entry,
// enable counts each further cycle, at_max flags HOLD_MAX.
module hold_counter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= CNT_W'(1);
        else if (enable)
            count <= count + CNT_W'(1);
    end

    assign at_max = (count == CNT_W'(HOLD_MAX));

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the 2:1 mux select line,
// with request/grant/done handshake and bounded hold time.
module mux_select_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic done,
    output logic select,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic timeout
);

    state_t state;
    state_t state_n;
    logic last_a;
    logic last_a_n;
    logic sel_n;
    logic to_n;
    logic clear;
    logic enable;
    logic req_x;
    logic at_max;
    logic [CNT_W-1:0] count;

    hold_counter #(
        .HOLD_MAX(HOLD_MAX),
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .enable(enable),
        .count (count),
        .at_max(at_max)
    );

    always_comb begin
        state_n  = state;
        last_a_n = last_a;
        sel_n    = select;
        to_n     = 1'b0;
        clear    = 1'b0;
        enable   = 1'b0;
        req_x    = 1'b0;
        unique case (state)
            IDLE: begin
                // On contention the requester not served last wins
                if (req_a && (!req_b || !last_a)) begin
                    state_n  = GRANT_A;
                    last_a_n = 1'b1;
                    sel_n    = SEL_A;
                    clear    = 1'b1;
                end else if (req_b) begin
                    state_n  = GRANT_B;
                    last_a_n = 1'b0;
                    sel_n    = SEL_B;
                    clear    = 1'b1;
                end
            end
            GRANT_A, GRANT_B: begin
                req_x = (state == GRANT_A) ? req_a : req_b;
                if (done || !req_x) begin
                    state_n = IDLE;
                end else if (at_max) begin
                    state_n = IDLE;
                    to_n    = 1'b1;
                end else begin
                    enable = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_a  <= 1'b0;
            select  <= SEL_B;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            last_a  <= last_a_n;
            select  <= sel_n;
            gnt_a   <= (state_n == GRANT_A);
            gnt_b   <= (state_n == GRANT_B);
            busy    <= (state_n != IDLE);
            timeout <= to_n;
        end
    end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench for mux_select_arbiter: HOLD_MAX=4 and
// HOLD_MAX=1 instances share stimulus, each with its own model.
module tb_mux_select_arbiter;

    typedef struct packed {
        logic sel;
        logic ga;
        logic gb;
        logic busy;
        logic to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic done = 1'b0;

    logic sel4, ga4, gb4, busy4, to4;
    logic sel1, ga1, gb1, busy1, to1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q4[$];
    exp_t q1[$];

    // Reference model: 0 = nobody holds, 1 = A holds, 2 = B holds
    int   holder[2];
    int   held[2];
    int   last[2];
    logic msel[2];
    logic mto[2];
    int   hm[2];

    always #5 clk = ~clk;

    mux_select_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .done(done), .select(sel4), .gnt_a(ga4), .gnt_b(gb4),
        .busy(busy4), .timeout(to4)
    );

    mux_select_arbiter #(.HOLD_MAX(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .done(done), .select(sel1), .gnt_a(ga1), .gnt_b(gb1),
        .busy(busy1), .timeout(to1)
    );

    task automatic model_step(input int k);
        int w;
        logic rq;
        if (rst) begin
            holder[k] = 0;
            held[k]   = 0;
            last[k]   = 2;
            msel[k]   = 1'b0;
            mto[k]    = 1'b0;
        end else if (holder[k] == 0) begin
            mto[k] = 1'b0;
            if (req_a && req_b)
                w = (last[k] == 1) ? 2 : 1;
            else if (req_a)
                w = 1;
            else if (req_b)
                w = 2;
            else
                w = 0;
            if (w != 0) begin
                holder[k] = w;
                held[k]   = 1;
                last[k]   = w;
                msel[k]   = (w == 1);
            end
        end else begin
            rq = (holder[k] == 1) ? req_a : req_b;
            if (done || !rq) begin
                holder[k] = 0;
                mto[k]    = 1'b0;
            end else if (held[k] == hm[k]) begin
                holder[k] = 0;
                mto[k]    = 1'b1;
            end else begin
                held[k] = held[k] + 1;
                mto[k]  = 1'b0;
            end
        end
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.sel  = msel[k];
        e.ga   = (holder[k] == 1);
        e.gb   = (holder[k] == 2);
        e.busy = (holder[k] != 0);
        e.to   = mto[k];
        return e;
    endfunction

    task automatic drive(input logic r, input logic a,
                         input logic b, input logic d);
        @(negedge clk);
        rst   = r;
        req_a = a;
        req_b = b;
        done  = d;
        model_step(0);
        model_step(1);
        q4.push_back(model_out(0));
        q1.push_back(model_out(1));
    endtask

    task automatic cmp(input string nm, input logic act,
                       input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%b want=%b",
                     nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            cmp("h4.select",  sel4,  e.sel);
            cmp("h4.gnt_a",   ga4,   e.ga);
            cmp("h4.gnt_b",   gb4,   e.gb);
            cmp("h4.busy",    busy4, e.busy);
            cmp("h4.timeout", to4,   e.to);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("h1.select",  sel1,  e.sel);
            cmp("h1.gnt_a",   ga1,   e.ga);
            cmp("h1.gnt_b",   gb1,   e.gb);
            cmp("h1.busy",    busy1, e.busy);
            cmp("h1.timeout", to1,   e.to);
        end
    end

    initial begin
        int waited;
        hm[0] = 4;
        hm[1] = 1;
        for (int k = 0; k < 2; k++) begin
            holder[k] = 0;
            held[k]   = 0;
            last[k]   = 2;
            msel[k]   = 1'b0;
            mto[k]    = 1'b0;
        end

        // Reset then single request from A, finished by done
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);

        // Contention with done pulsed each grant
        for (int i = 0; i < 12; i++)
            drive(0, 1, 1, (i % 2) == 1);

        // B alone, held through timeout and re-grant
        for (int i = 0; i < 14; i++)
            drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // A: done coincident with count==HOLD_MAX
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // A drops its request at count 2
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Reset mid-grant of B, then contention
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);
        for (int i = 0; i < 10; i++)
            drive(0, 1, 1, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0));

        drive(0, 0, 0, 0);
        waited = 0;
        while ((q4.size() > 0 || q1.size() > 0) && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        n_cmp++;
        if (q4.size() > 0 || q1.size() > 0) begin
            n_bad++;
            $display("FAIL drain got=%0d/%0d left want=0",
                     q4.size(), q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
